// File: rtl/capture_sequencer_pkg.sv
// Shared frame geometry, default parameters and state encoding for the
// capture sequencer and its neighbours (capture unit, VGA painter).
package capture_sequencer_pkg;

    localparam int FRAME_W         = 160;
    localparam int FRAME_H         = 120;
    localparam int FB_DEPTH_DEF    = FRAME_W * FRAME_H;
    localparam int CNT_W_DEF       = 15;
    localparam int TIMEOUT_CYC_DEF = 4_000_000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } seq_state_e;

    // Line counter saturates instead of wrapping so a runaway href is visible.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/capture_sequencer_edge_detect.sv
// One-bit registered edge detector; rise/fall are combinational from the
// current input against the registered previous value.
module capture_sequencer_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;
    assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/capture_sequencer.sv
// Gates capture-unit writes into the frame buffer on whole-frame boundaries,
// in continuous or snapshot mode, and keeps per-frame stats and sticky errors.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int FB_DEPTH    = FB_DEPTH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic             cap_we,
    input  logic             mode,
    input  logic             arm,
    input  logic             stop,
    output logic             fb_we,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_count,
    output logic [7:0]       line_count,
    output logic [CNT_W-1:0] word_count,
    output logic             overflow,
    output logic             short_frame,
    output logic             timeout
);

    localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(FB_DEPTH);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]       lcnt_q, lcnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic [7:0]       line_count_q, line_count_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             overflow_q, overflow_d;
    logic             short_q, short_d;
    logic             timeout_q, timeout_d;

    logic fs, fe, line_end, hr_rise_unused;
    logic timeout_hit;

    capture_sequencer_edge_detect #(.RESET_VAL(1'b1)) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_vsync),
        .rise_o (fe),
        .fall_o (fs)
    );

    capture_sequencer_edge_detect #(.RESET_VAL(1'b1)) u_hr_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_href),
        .rise_o (hr_rise_unused),
        .fall_o (line_end)
    );

    assign timeout_hit = ((state_q == ST_SYNC) || (state_q == ST_ACTIVE)) &&
                         (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (arm) state_d = ST_SYNC;
                ST_SYNC: begin
                    if (timeout_hit)  state_d = ST_SYNC;
                    else if (fs)      state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (timeout_hit)  state_d = ST_SYNC;
                    else if (fe)      state_d = ST_DONE;
                end
                ST_DONE:   state_d = mode ? ST_HOLD : ST_SYNC;
                ST_HOLD:   if (arm) state_d = ST_SYNC;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // fb_we is combinational so the capture unit's address/data stay aligned.
    always_comb begin
        fb_we      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_SYNC:   busy = 1'b1;
            ST_ACTIVE: begin
                busy  = 1'b1;
                fb_we = cap_we && (wcnt_q < DEPTH);
            end
            ST_DONE:   frame_done = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        wcnt_d        = wcnt_q;
        lcnt_d        = lcnt_q;
        timer_d       = timer_q;
        frame_count_d = frame_count_q;
        line_count_d  = line_count_q;
        word_count_d  = word_count_q;
        overflow_d    = overflow_q;
        short_d       = short_q;
        timeout_d     = timeout_q;

        if (state_q == ST_SYNC && state_d == ST_ACTIVE) begin
            wcnt_d = '0;
            lcnt_d = '0;
        end else if (state_q == ST_ACTIVE) begin
            if (fb_we)    wcnt_d = wcnt_q + 1'b1;
            if (line_end) lcnt_d = sat_inc8(lcnt_q);
        end

        // Watchdog only runs while waiting on or receiving a frame.
        if (!busy || (state_d != state_q) || fs || fe || timeout_hit) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (state_q == ST_DONE) begin
            word_count_d  = wcnt_q;
            line_count_d  = lcnt_q;
            frame_count_d = frame_count_q + 8'd1;
            if (wcnt_q < DEPTH) short_d = 1'b1;
        end

        if (!stop) begin
            if (state_q == ST_ACTIVE && cap_we && wcnt_q >= DEPTH) overflow_d = 1'b1;
            if (timeout_hit) timeout_d = 1'b1;
            if (state_q == ST_IDLE && arm) begin
                overflow_d = 1'b0;
                short_d    = 1'b0;
                timeout_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q        <= '0;
            lcnt_q        <= '0;
            timer_q       <= '0;
            frame_count_q <= '0;
            line_count_q  <= '0;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
            short_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            lcnt_q        <= lcnt_d;
            timer_q       <= timer_d;
            frame_count_q <= frame_count_d;
            line_count_q  <= line_count_d;
            word_count_q  <= word_count_d;
            overflow_q    <= overflow_d;
            short_q       <= short_d;
            timeout_q     <= timeout_d;
        end
    end

    assign frame_count = frame_count_q;
    assign line_count  = line_count_q;
    assign word_count  = word_count_q;
    assign overflow    = overflow_q;
    assign short_frame = short_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a cycle-accurate vector table plus
// full-size frame sequences; a second instance has a short watchdog.
module tb_capture_sequencer;

    localparam int CNT_W    = 15;
    localparam int FB_DEPTH = 19200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cam_vsync, cam_href, cap_we, mode, arm, stop;

    logic             fb_we, busy, frame_done, overflow, short_frame, timeout;
    logic [7:0]       frame_count, line_count;
    logic [CNT_W-1:0] word_count;

    logic             fb_we_t, busy_t, frame_done_t, overflow_t, short_frame_t, timeout_t;
    logic [7:0]       frame_count_t, line_count_t;
    logic [CNT_W-1:0] word_count_t;

    // Main instance: watchdog long enough for a full-size frame.
    capture_sequencer #(.FB_DEPTH(FB_DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(50000)) dut (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cap_we(cap_we), .mode(mode), .arm(arm), .stop(stop),
        .fb_we(fb_we), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .line_count(line_count), .word_count(word_count),
        .overflow(overflow), .short_frame(short_frame), .timeout(timeout)
    );

    // Watchdog instance with the shortened timeout.
    capture_sequencer #(.FB_DEPTH(FB_DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(1000)) dut_to (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cap_we(cap_we), .mode(mode), .arm(arm), .stop(stop),
        .fb_we(fb_we_t), .busy(busy_t), .frame_done(frame_done_t),
        .frame_count(frame_count_t), .line_count(line_count_t), .word_count(word_count_t),
        .overflow(overflow_t), .short_frame(short_frame_t), .timeout(timeout_t)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_we     = 0;
    int n_done   = 0;

    always @(negedge clk) begin
        if (fb_we)      n_we   <= n_we + 1;
        if (frame_done) n_done <= n_done + 1;
    end

    typedef struct {
        logic             vs, hr, we, arm, stop;
        logic             exp_we, exp_busy, exp_done;
        logic [7:0]       exp_fc, exp_lc;
        logic [CNT_W-1:0] exp_wc;
        logic             exp_short;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic vs, hr, we, a, s, ew, eb, ed,
                                input int fc, lc, wc, input logic sh);
        vec_t v;
        v.vs = vs; v.hr = hr; v.we = we; v.arm = a; v.stop = s;
        v.exp_we = ew; v.exp_busy = eb; v.exp_done = ed;
        v.exp_fc = 8'(fc); v.exp_lc = 8'(lc); v.exp_wc = CNT_W'(wc); v.exp_short = sh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic hr, input logic we);
        cam_vsync = vs; cam_href = hr; cap_we = we; arm = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    // Blanking, fs, `lines` lines of `wpl` writes (last line `last_wpl`), fe, blanking.
    task automatic frame(input int lines, input int wpl, input int last_wpl);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            repeat ((l == lines - 1) ? last_wpl : wpl) cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int we0, done0, n;

        //            vs hr we arm stp  we bsy dn  fc lc wc sh
        tbl[0]  = mk(1, 0, 1, 1, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0,   1, 1, 0,   0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 1, 0,   1, 1, 0,   0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0,   1, 1, 0,   0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 1, 0, 0,   1, 1, 0,   0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0,   0, 0, 1,   0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 1, 0, 0,   0, 0, 0,   1, 2, 4, 1);
        tbl[10] = mk(0, 0, 1, 0, 0,   0, 0, 0,   1, 2, 4, 1);
        tbl[11] = mk(0, 1, 1, 0, 0,   0, 0, 0,   1, 2, 4, 1);
        tbl[12] = mk(1, 0, 0, 1, 0,   0, 0, 0,   1, 2, 4, 1);
        tbl[13] = mk(1, 0, 1, 0, 0,   0, 1, 0,   1, 2, 4, 1);
        tbl[14] = mk(0, 0, 1, 0, 0,   0, 1, 0,   1, 2, 4, 1);
        tbl[15] = mk(0, 1, 1, 0, 0,   1, 1, 0,   1, 2, 4, 1);
        tbl[16] = mk(0, 1, 1, 0, 1,   1, 1, 0,   1, 2, 4, 1);
        tbl[17] = mk(0, 1, 1, 0, 0,   0, 0, 0,   1, 2, 4, 1);
        tbl[18] = mk(0, 1, 1, 0, 0,   0, 0, 0,   1, 2, 4, 1);

        // Reset values, with a write strobe present in IDLE.
        rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cap_we = 1'b1;
        mode = 1'b0; arm = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_fb_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_line_count", line_count, 0);
        check("rst_word_count", word_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_short_frame", short_frame, 0);
        check("rst_timeout", timeout, 0);
        check("rst_timeout_t", timeout_t, 0);

        // Timeout: arm with vsync held low; watchdog instance fires after 1000 cycles.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        pulse_arm();
        n = 0;
        while (timeout_t !== 1'b1 && n < 1100) begin
            cyc(1'b0, 1'b0, 1'b1);
            n++;
        end
        #2;
        check("timeout_cycles", n, 1000);
        check("timeout_flag", timeout_t, 1);
        check("timeout_state_sync", busy_t, 1);
        check("timeout_fb_we", fb_we_t, 0);
        check("timeout_frame_count", frame_count_t, 0);
        check("timeout_frame_done", frame_done_t, 0);
        check("timeout_word_count", word_count_t, 0);
        check("timeout_line_count", line_count_t, 0);
        check("timeout_no_overflow", overflow_t, 0);
        check("timeout_no_short", short_frame_t, 0);
        check("timeout_long_instance", timeout, 0);
        pulse_stop();

        // Cycle-accurate table: tiny snapshot frame, HOLD, re-arm, stop mid-ACTIVE.
        mode = 1'b1;
        for (int i = 0; i < 19; i++) begin
            cam_vsync = tbl[i].vs; cam_href = tbl[i].hr; cap_we = tbl[i].we;
            arm = tbl[i].arm; stop = tbl[i].stop;
            #2;
            check($sformatf("tbl%0d_fb_we", i), fb_we, tbl[i].exp_we);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].exp_done);
            check($sformatf("tbl%0d_frame_count", i), frame_count, tbl[i].exp_fc);
            check($sformatf("tbl%0d_line_count", i), line_count, tbl[i].exp_lc);
            check($sformatf("tbl%0d_word_count", i), word_count, tbl[i].exp_wc);
            check($sformatf("tbl%0d_short", i), short_frame, tbl[i].exp_short);
            @(posedge clk); #1;
        end
        arm = 1'b0; stop = 1'b0;

        // Single-shot full frame, then the buffer stays frozen in HOLD.
        cyc(1'b1, 1'b0, 1'b0);
        pulse_arm();
        we0 = n_we; done0 = n_done;
        frame(120, 160, 160);
        check("ss_writes", n_we - we0, 19200);
        check("ss_done_pulses", n_done - done0, 1);
        check("ss_word_count", word_count, 19200);
        check("ss_line_count", line_count, 120);
        check("ss_frame_count", frame_count, 2);
        check("ss_short", short_frame, 0);
        check("ss_overflow", overflow, 0);
        check("ss_hold_busy", busy, 0);
        we0 = n_we; done0 = n_done;
        frame(2, 4, 4);
        check("hold_writes", n_we - we0, 0);
        check("hold_done_pulses", n_done - done0, 0);
        check("hold_frame_count", frame_count, 2);
        pulse_stop();

        // Continuous mode: three back-to-back small frames.
        mode = 1'b0;
        pulse_arm();
        we0 = n_we; done0 = n_done;
        for (int f = 0; f < 3; f++) begin
            frame(2, 4, 4);
            check($sformatf("cont%0d_busy", f), busy, 1);
        end
        check("cont_done_pulses", n_done - done0, 3);
        check("cont_writes", n_we - we0, 24);
        check("cont_frame_count", frame_count, 5);
        check("cont_word_count", word_count, 8);
        pulse_stop();

        // Long frame then short frame; flags survive stop, cleared by arm from IDLE.
        pulse_arm();
        check("arm_clears_short", short_frame, 0);
        we0 = n_we;
        frame(121, 160, 100);
        check("long_writes", n_we - we0, 19200);
        check("long_word_count", word_count, 19200);
        check("long_line_count", line_count, 121);
        check("long_overflow", overflow, 1);
        check("long_short", short_frame, 0);
        frame(100, 160, 160);
        check("short_word_count", word_count, 16000);
        check("short_line_count", line_count, 100);
        check("short_flag", short_frame, 1);
        check("short_overflow_kept", overflow, 1);
        check("short_frame_count", frame_count, 7);
        pulse_stop();
        check("stop_keeps_overflow", overflow, 1);
        check("stop_keeps_short", short_frame, 1);
        pulse_arm();
        check("rearm_clears_overflow", overflow, 0);
        check("rearm_clears_short", short_frame, 0);

        // Reset mid-frame: everything back to reset values, no frame_done.
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        #2;
        check("midframe_fb_we", fb_we, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("mrst_fb_we", fb_we, 0);
        check("mrst_busy", busy, 0);
        check("mrst_frame_count", frame_count, 0);
        check("mrst_word_count", word_count, 0);
        check("mrst_line_count", line_count, 0);
        done0 = n_done;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("mrst_no_done", n_done - done0, 0);

        // frame_count wraps 255 -> 0.
        pulse_arm();
        repeat (255) frame(1, 1, 1);
        check("wrap_255", frame_count, 255);
        frame(1, 1, 1);
        check("wrap_0", frame_count, 0);
        check("wrap_word_count", word_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences frame capture from the OV7670 capture path into the 160x120 frame buffer. Sits between the capture unit's write strobe and the frame buffer write port. It gates writes to whole frames only, in either continuous mode or single-shot (snapshot) mode, and freezes the buffer after a snapshot so downstream laser-spot logic and the VGA painter read a stable image. Reports frame completion, per-frame statistics and sticky error flags.

## Interface
- FB_DEPTH, 19200: frame buffer words per frame (160x120).
- CNT_W, 15: width of the write counter and address path.
- TIMEOUT_CYC, 4000000: clk cycles without a vsync edge before a timeout is declared (about 80 ms at 50 MHz).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera vsync, already synchronous to clk; high during vertical blanking.
- cam_href  in  1  camera href, already synchronous to clk.
- cap_we  in  1  write strobe from the capture unit.
- mode  in  1  0 = continuous, 1 = single-shot; sampled only in IDLE, HOLD and DONE.
- arm  in  1  one-cycle start / re-arm pulse.
- stop  in  1  one-cycle abort pulse.
- fb_we  out  1  gated write enable to the frame buffer.
- busy  out  1  high in SYNC and ACTIVE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_count  out  8  number of completed frames; wraps 255 -> 0.
- line_count  out  8  href falling edges in the last completed frame.
- word_count  out  CNT_W  writes accepted in the last completed frame.
- overflow  out  1  sticky: a write was dropped because FB_DEPTH was reached.
- short_frame  out  1  sticky: a frame ended with word_count < FB_DEPTH.
- timeout  out  1  sticky: no vsync edge within TIMEOUT_CYC.

## Operation
- **States:** IDLE, SYNC, ACTIVE, DONE, HOLD.
- **Edge detection:** `vs_prev` and `hr_prev` are registered copies of the inputs; both reset to 1.
  - frame start (fs) = `!cam_vsync & vs_prev`.
  - frame end (fe) = `cam_vsync & !vs_prev`.
  - line end = `!cam_href & hr_prev`.
- **IDLE:**
  - `arm` -> SYNC.
  - `arm` also clears overflow, short_frame and timeout.
- **SYNC:**
  - fs -> ACTIVE.
  - On entry to ACTIVE, the write counter and the line counter are cleared.
- **ACTIVE:**
  - fb_we = cap_we & (wcnt < FB_DEPTH).
  - wcnt increments on every accepted write.
  - If cap_we is high while wcnt == FB_DEPTH, the write is dropped and overflow is set.
  - The line counter increments on each line end and saturates at 255.
  - fe -> DONE.
- **DONE (exactly one cycle):**
  - frame_done = 1.
  - word_count and line_count latch the counters.
  - frame_count increments.
  - short_frame is set if wcnt < FB_DEPTH.
  - Next state: mode = 0 -> SYNC; mode = 1 -> HOLD.
- **HOLD:**
  - fb_we = 0; the buffer is frozen.
  - `arm` -> SYNC. The sticky flags are not cleared.
- **Timeout:**
  - A timer counts in SYNC and ACTIVE and restarts on any vsync edge or state change.
  - On reaching TIMEOUT_CYC: set timeout, go to SYNC, discard partial counts.
  - No frame_done, and no change to frame_count.
- **stop:**
  - From any state -> IDLE on the next edge; fb_we = 0 from that edge onward.
  - A partial frame is discarded and its statistics are not latched.
- **Priority:** rst > stop > timeout > fe/fs > arm.
  - `arm` while in SYNC or ACTIVE is ignored.

## Timing
- **Reset values:** state = IDLE; fb_we = 0; busy = 0; frame_done = 0; frame_count = 0; line_count = 0; word_count = 0; all sticky flags = 0; wcnt = 0; timer = 0.
- **fb_we latency:** zero-latency combinational gating of cap_we by the registered state and wcnt, so the capture unit's address and data stay aligned to fb_we.
- **Start latency:** fs is detected 1 cycle after cam_vsync falls; ACTIVE is entered on the following edge. The first write accepted is the one in the cycle after that edge.
- **End latency:** fe moves ACTIVE -> DONE on the edge after cam_vsync rises; frame_done is high for the next cycle. A cap_we in the same cycle as fe is still accepted.
- **Continuous mode:** DONE -> SYNC with no lost frame, because the next fs comes at least one blanking period later.
- **frame_count wrap:** 255 -> 0, with no flag.
- **Reset mid-frame:** the partial frame is discarded; no frame_done pulse.

## Structure
- Shared header `camera_defs.vh` holds:
  - the state encodings (3-bit localparams);
  - FB_DEPTH and the frame width and height constants, also used by capture and painter.
- One natural sub-module, `edge_detect`: a 1-bit registered rise/fall detector with a reset value parameter. Instantiate it twice, for vsync and href.

## Test plan
- **Single-shot frame:** mode = 1, arm, then one 120-line x 160-write frame. Expect fb_we asserted for exactly 19200 writes, one frame_done pulse, word_count = 19200, line_count = 120, state HOLD, and fb_we = 0 for all later cap_we.
- **Continuous mode:** mode = 0, arm, three frames. Expect frame_count = 3 and three frame_done pulses, with SYNC/ACTIVE alternation and no frames skipped.
- **Long and short frames:**
  - A frame with 19300 writes -> 19200 accepted, overflow = 1.
  - A next frame with 100 lines -> word_count = 16000, short_frame = 1.
  - Both flags stay set until the next arm from IDLE.
- **Timeout:** arm with vsync held low. Expect timeout = 1 after TIMEOUT_CYC cycles (override to 1000 in the bench), state SYNC, frame_count unchanged.
- **Aborts:**
  - stop mid-ACTIVE -> IDLE the next cycle, fb_we = 0, no frame_done, word_count unchanged.
  - rst mid-frame -> all outputs at their reset values.
- **Re-arm and event collisions:**
  - arm in HOLD -> capture resumes at the next fs.
  - arm asserted during ACTIVE -> ignored.
  - fe and cap_we in the same cycle -> the write is counted.
